// File: rtl/dut_io_bridge.sv
// Purpose: glue between the AXI slave register file and an fpga_top-style DUT (switches, buttons, LEDs, 7-seg, status).
// Latency: switches/LEDs/status 1 cycle; buttons 2 sync + DEB_CYCLES debounce + 1 output cycle; 7-seg 1 cycle.
// Backpressure: none; all paths are free-running level/register images sampled every cycle.
module dut_io_bridge #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int N_SW               = 16,
    parameter int N_BTN              = 5,
    parameter int DEB_CYCLES         = 4,
    parameter int N_DIGITS           = 4,
    parameter int SCAN_DIV           = 1000
) (
    input  logic                          sysclk,
    input  logic                          rst_n,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] read_from_slv_reg1,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] read_from_slv_reg2,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] read_from_slv_reg3,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] read_from_slv_reg4,
    output logic [C_S_AXI_DATA_WIDTH-1:0] write_to_slv_reg5,
    output logic [C_S_AXI_DATA_WIDTH-1:0] write_to_slv_reg6,
    output logic [C_S_AXI_DATA_WIDTH-1:0] write_to_slv_reg7,
    output logic [N_SW-1:0]               dut_sw,
    output logic [N_BTN-1:0]              dut_btn,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] dut_led,
    input  logic [4*N_DIGITS-1:0]         dut_disp,
    input  logic                          dut_done
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [1:0] MODE_LEVEL  = 2'b00;
    localparam logic [1:0] MODE_PULSE  = 2'b01;
    localparam logic [1:0] MODE_TOGGLE = 2'b10;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] f_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    f_seg = 7'b1000000;
            4'h1:    f_seg = 7'b1111001;
            4'h2:    f_seg = 7'b0100100;
            4'h3:    f_seg = 7'b0110000;
            4'h4:    f_seg = 7'b0011001;
            4'h5:    f_seg = 7'b0010010;
            4'h6:    f_seg = 7'b0000010;
            4'h7:    f_seg = 7'b1111000;
            4'h8:    f_seg = 7'b0000000;
            4'h9:    f_seg = 7'b0010000;
            4'hA:    f_seg = 7'b0001000;
            4'hB:    f_seg = 7'b0000011;
            4'hC:    f_seg = 7'b1000110;
            4'hD:    f_seg = 7'b0100001;
            4'hE:    f_seg = 7'b0000110;
            default: f_seg = 7'b0001110;
        endcase
    endfunction

    // Button conditioning state
    logic [N_BTN-1:0]         r_sync1;
    logic [N_BTN-1:0]         r_sync2;
    logic [N_BTN-1:0]         r_db;
    logic [N_BTN-1:0]         r_rise;
    logic [N_BTN-1:0]         r_tg;
    logic [N_BTN-1:0][CW-1:0] r_deb_cnt;
    logic [N_BTN-1:0]         w_db_next;
    logic [N_BTN-1:0]         w_db_rise;
    logic [N_BTN-1:0]         w_tg_next;
    logic [N_BTN-1:0]         w_btn_next;
    logic [N_BTN-1:0][CW-1:0] w_cnt_next;

    // Display scan state
    logic [SW-1:0]            r_scan;
    logic [DW-1:0]            r_digit;
    logic [3:0]               w_nib;
    logic [N_DIGITS-1:0]      w_anode;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_reg6_next;

    // Status state
    logic                     r_sticky;
    logic                     r_done;
    logic [7:0]               r_press_cnt;
    logic                     w_clr;

    // Register bits outside the used fields are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{read_from_slv_reg1, read_from_slv_reg2, read_from_slv_reg3, read_from_slv_reg4};

    assign w_clr = read_from_slv_reg1[0];

    // Debounce: accept the synced value once it has differed for DEB_CYCLES cycles in a row.
    always_comb begin
        w_db_next  = r_db;
        w_cnt_next = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (r_sync2[i] != r_db[i]) begin
                if (r_deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    w_db_next[i] = r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_deb_cnt[i] + 1'b1;
                end
            end
        end
        w_db_rise = w_db_next & ~r_db;
    end

    // Per-button behaviour: toggle state and next output image from the current mode.
    always_comb begin
        w_tg_next  = '0;
        w_btn_next = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (read_from_slv_reg4[2*i +: 2] == MODE_TOGGLE) begin
                w_tg_next[i] = r_tg[i] ^ w_db_rise[i];
            end
            case (read_from_slv_reg4[2*i +: 2])
                MODE_LEVEL:  w_btn_next[i] = r_db[i];
                MODE_PULSE:  w_btn_next[i] = r_rise[i];
                MODE_TOGGLE: w_btn_next[i] = r_tg[i];
                default:     w_btn_next[i] = ~r_db[i];
            endcase
        end
    end

    // Button pipeline: synchroniser, debounce, edge/toggle state and registered output.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db      <= '0;
            r_rise    <= '0;
            r_tg      <= '0;
            r_deb_cnt <= '0;
            dut_btn   <= '0;
        end else begin
            r_sync1   <= read_from_slv_reg3[N_BTN-1:0];
            r_sync2   <= r_sync1;
            r_db      <= w_db_next;
            r_rise    <= w_db_rise;
            r_tg      <= w_tg_next;
            r_deb_cnt <= w_cnt_next;
            dut_btn   <= w_btn_next;
        end
    end

    // Straight register images: switches to the DUT, LEDs back to AXI.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            dut_sw            <= '0;
            write_to_slv_reg5 <= '0;
        end else begin
            dut_sw            <= read_from_slv_reg2[N_SW-1:0];
            write_to_slv_reg5 <= dut_led;
        end
    end

    // Scan timebase: hold each digit for SCAN_DIV cycles, then move to the next.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan  <= '0;
            r_digit <= '0;
        end else if (r_scan == SW'(SCAN_DIV - 1)) begin
            r_scan <= '0;
            if (N_DIGITS == 1 || r_digit == DW'(N_DIGITS - 1)) begin
                r_digit <= '0;
            end else begin
                r_digit <= r_digit + 1'b1;
            end
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    // 7-seg image: live nibble of the current digit, DP off, active-low anode.
    always_comb begin
        w_nib       = dut_disp[4*r_digit +: 4];
        w_anode     = ~(N_DIGITS'(1) << r_digit);
        w_reg6_next = '0;
        w_reg6_next[6:0]          = f_seg(w_nib);
        w_reg6_next[7]            = 1'b1;
        w_reg6_next[8 +: N_DIGITS] = w_anode;
    end

    // Registered 7-seg image.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            write_to_slv_reg6 <= '0;
        end else begin
            write_to_slv_reg6 <= w_reg6_next;
        end
    end

    // Status: sticky done, live done, press counter; clear dominates set and increment.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky    <= 1'b0;
            r_done      <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_done <= dut_done;
            if (w_clr) begin
                r_sticky    <= 1'b0;
                r_press_cnt <= '0;
            end else begin
                r_sticky <= r_sticky | dut_done;
                if (|w_db_rise) begin
                    r_press_cnt <= r_press_cnt + 1'b1;
                end
            end
        end
    end

    // Status word layout: [15:8] press count, [1] live done, [0] sticky done.
    always_comb begin
        write_to_slv_reg7        = '0;
        write_to_slv_reg7[0]     = r_sticky;
        write_to_slv_reg7[1]     = r_done;
        write_to_slv_reg7[15:8]  = r_press_cnt;
    end

endmodule

// File: tb/tb_dut_io_bridge.sv
// Scoreboard bench for dut_io_bridge: stimulus pushes expected (cycle, value) pairs,
// a negedge monitor pops one entry per observed output change and compares it.
// Small DEB_CYCLES/SCAN_DIV keep the run short.
module tb_dut_io_bridge;

    localparam int W = 32;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic [W-1:0] reg1, reg2, reg3, reg4;
    logic [W-1:0] reg5, reg6, reg7;
    logic [15:0] dut_sw;
    logic [4:0]  dut_btn;
    logic [W-1:0] dut_led;
    logic [15:0] dut_disp;
    logic        dut_done;

    dut_io_bridge #(
        .C_S_AXI_DATA_WIDTH(32), .N_SW(16), .N_BTN(5),
        .DEB_CYCLES(4), .N_DIGITS(4), .SCAN_DIV(4)
    ) u_dut (
        .sysclk(sysclk), .rst_n(rst_n),
        .read_from_slv_reg1(reg1), .read_from_slv_reg2(reg2),
        .read_from_slv_reg3(reg3), .read_from_slv_reg4(reg4),
        .write_to_slv_reg5(reg5), .write_to_slv_reg6(reg6), .write_to_slv_reg7(reg7),
        .dut_sw(dut_sw), .dut_btn(dut_btn),
        .dut_led(dut_led), .dut_disp(dut_disp), .dut_done(dut_done)
    );

    always #5 sysclk = ~sysclk;

    // Cycle number = posedges since the last reset release.
    int cyc;
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          c;
        logic [31:0] v;
    } exp_t;

    exp_t q_sw[$], q_btn[$], q_r5[$], q_r6[$], q_r7[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 0;
    bit   seg_en = 0;
    logic [31:0] p_sw = '0, p_btn = '0, p_r5 = '0, p_r6 = '0, p_r7 = '0;

    task automatic cmp(input string name, input exp_t e, input logic [31:0] act);
        n_cmp++;
        if (e.c != cyc || e.v !== act) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d", name, act, cyc, e.v, e.c);
        end
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected change to 0x%0h at cycle %0d, nothing expected", name, act, cyc);
    endtask

    task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic qempty(input string name, input int sz);
        n_cmp++;
        if (sz != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected changes never seen, expected 0 left", name, sz);
        end
    endtask

    // Monitor: every output change consumes one scoreboard entry.
    always @(negedge sysclk) begin
        if (mon_en && rst_n) begin
            if (32'(dut_sw) != p_sw) begin
                if (q_sw.size() == 0) unexp("dut_sw", 32'(dut_sw));
                else cmp("dut_sw", q_sw.pop_front(), 32'(dut_sw));
            end
            if (32'(dut_btn) != p_btn) begin
                if (q_btn.size() == 0) unexp("dut_btn", 32'(dut_btn));
                else cmp("dut_btn", q_btn.pop_front(), 32'(dut_btn));
            end
            if (reg5 != p_r5) begin
                if (q_r5.size() == 0) unexp("reg5", reg5);
                else cmp("reg5", q_r5.pop_front(), reg5);
            end
            if (seg_en && reg6 != p_r6) begin
                if (q_r6.size() == 0) unexp("reg6", reg6);
                else cmp("reg6", q_r6.pop_front(), reg6);
            end
            if (reg7 != p_r7) begin
                if (q_r7.size() == 0) unexp("reg7", reg7);
                else cmp("reg7", q_r7.pop_front(), reg7);
            end
        end
        p_sw  = 32'(dut_sw);
        p_btn = 32'(dut_btn);
        p_r5  = reg5;
        p_r6  = reg6;
        p_r7  = reg7;
    end

    task automatic e_sw (input int lat, input logic [31:0] v); q_sw.push_back('{cyc + lat, v});  endtask
    task automatic e_btn(input int lat, input logic [31:0] v); q_btn.push_back('{cyc + lat, v}); endtask
    task automatic e_r5 (input int lat, input logic [31:0] v); q_r5.push_back('{cyc + lat, v});  endtask
    task automatic e_r7 (input int lat, input logic [31:0] v); q_r7.push_back('{cyc + lat, v});  endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge sysclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] seg_seq [4];

    initial begin
        seg_seq[0] = 32'h0E90;  // digit 0 = 9
        seg_seq[1] = 32'h0DC0;  // digit 1 = 0
        seg_seq[2] = 32'h0B8E;  // digit 2 = F
        seg_seq[3] = 32'h07B0;  // digit 3 = 3

        rst_n = 1'b0;
        reg1 = '0; reg2 = '0; reg3 = '0; reg4 = '0;
        dut_led = '0; dut_disp = 16'h3F09; dut_done = 1'b0;
        repeat (3) @(negedge sysclk);
        reg2 = 32'h0000A5C3;
        @(negedge sysclk);
        dchk("reset dut_sw", 32'(dut_sw), 32'h0);
        dchk("reset dut_btn", 32'(dut_btn), 32'h0);
        dchk("reset reg5", reg5, 32'h0);
        dchk("reset reg6", reg6, 32'h0);
        dchk("reset reg7", reg7, 32'h0);

        // Release: switches appear after one cycle, scan starts at digit 0.
        e_sw(1, 32'hA5C3);
        for (int k = 0; k < 8; k++) q_r6.push_back('{1 + 4 * k, seg_seq[k % 4]});
        mon_en = 1; seg_en = 1;
        rst_n  = 1'b1;

        at(2);  dut_led = 32'h12345678; e_r5(1, 32'h12345678);
        at(3);  reg2 = 32'hFFFF1234;    e_sw(1, 32'h1234);
        at(5);  dut_led = 32'hDEADBEEF; e_r5(1, 32'hDEADBEEF);

        // Button 0 level: held 10 cycles, then a 3-cycle bounce that must be rejected.
        at(10); reg3 = 32'h1; e_r7(6, 32'h100); e_btn(7, 32'h1);
        at(20); reg3 = 32'h0; e_btn(7, 32'h0);
        at(30); reg3 = 32'h1;
        at(31); seg_en = 0;
        at(33); reg3 = 32'h0;

        // Clear press count, then button 1 in pulse mode.
        at(36); reg1 = 32'h1; e_r7(1, 32'h0);
        at(37); reg1 = 32'h0;
        at(40); reg4 = 32'h4;
        at(42); reg3 = 32'h2; e_r7(6, 32'h100); e_btn(7, 32'h2); e_btn(8, 32'h0);
        at(62); reg3 = 32'h0;
        // Simultaneous rises count once.
        at(75); reg3 = 32'h3; e_r7(6, 32'h200); e_btn(7, 32'h3); e_btn(8, 32'h1);
        at(90); reg3 = 32'h0; e_btn(7, 32'h0);
        // Entering pulse mode while held gives no pulse; inverted level mode.
        at(100); reg3 = 32'h1; e_r7(6, 32'h300); e_btn(7, 32'h1);
        at(110); reg4 = 32'h5; e_btn(1, 32'h0);
        at(115); reg4 = 32'h4; e_btn(1, 32'h1);
        at(118); reg3 = 32'h0; e_btn(7, 32'h0);
        at(130); reg4 = 32'h7; e_btn(1, 32'h1);
        at(135); reg4 = 32'h4; e_btn(1, 32'h0);

        // Button 2 toggle: two presses 0->1->0, then mode change clears tg.
        at(140); reg4 = 32'h24;
        at(145); reg3 = 32'h4; e_r7(6, 32'h400); e_btn(7, 32'h4);
        at(155); reg3 = 32'h0;
        at(165); reg3 = 32'h4; e_r7(6, 32'h500); e_btn(7, 32'h0);
        at(175); reg3 = 32'h0;
        at(185); reg3 = 32'h4; e_r7(6, 32'h600); e_btn(7, 32'h4);
        at(195); reg4 = 32'h04;
        at(200); reg3 = 32'h0; e_btn(7, 32'h0);
        at(210); reg4 = 32'h24;
        at(215); reg3 = 32'h4; e_r7(6, 32'h700); e_btn(7, 32'h4);
        at(225); reg3 = 32'h0;
        at(235); reg4 = 32'h04; e_btn(1, 32'h0);

        // Done sticky, then clear with done asserted in the same cycle.
        at(240); dut_done = 1'b1; e_r7(1, 32'h703);
        at(241); dut_done = 1'b0; e_r7(1, 32'h701);
        at(250); reg1 = 32'h1; dut_done = 1'b1; e_r7(1, 32'h002);
        at(251); reg1 = 32'h0; dut_done = 1'b0; e_r7(1, 32'h000);

        // 256 presses: counter wraps 255 -> 0.
        for (int k = 0; k < 256; k++) begin
            at(260 + 20 * k);
            reg3 = 32'h1;
            e_btn(7, 32'h1);
            e_r7(6, 32'(((k + 1) % 256) << 8));
            at(268 + 20 * k);
            reg3 = 32'h0;
            e_btn(7, 32'h0);
        end

        // Toggle set, then reset mid-toggle and mid-debounce.
        at(5400); reg4 = 32'h20; reg3 = 32'h4; e_r7(6, 32'h100); e_btn(7, 32'h4);
        at(5410); reg3 = 32'h5;
        at(5412);
        mon_en = 0;
        qempty("q dut_sw", q_sw.size());
        qempty("q dut_btn", q_btn.size());
        qempty("q reg5", q_r5.size());
        qempty("q reg6", q_r6.size());
        qempty("q reg7", q_r7.size());
        rst_n = 1'b0;
        @(negedge sysclk);
        dchk("reset2 dut_sw", 32'(dut_sw), 32'h0);
        dchk("reset2 dut_btn", 32'(dut_btn), 32'h0);
        dchk("reset2 reg5", reg5, 32'h0);
        dchk("reset2 reg6", reg6, 32'h0);
        dchk("reset2 reg7", reg7, 32'h0);
        reg3 = 32'h0;
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (20) @(negedge sysclk);
        dchk("post-reset dut_btn", 32'(dut_btn), 32'h0);
        dchk("post-reset reg7", reg7, 32'h0);
        dchk("post-reset dut_sw", 32'(dut_sw), 32'h1234);
        dchk("post-reset reg5", reg5, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
